uart_rx_buffer: RTL

Receive-side elastic buffer that sits directly downstream of the UART receive path. It captures each completed word, qualified by the rising edge of the receiver's Flag_Rx strobe, together with its parity-error status. Words are held in a show-ahead FIFO so the host can read at its own pace. The block also reports fill level, overrun and a saturating parity-error count.

---
 rtl/uart_rx_buffer_pkg.sv | 36 +++
 rtl/uart_rx_buffer_sync_fifo_core.sv | 62 ++++++
 rtl/uart_rx_buffer.sv | 92 +++++++++
 3 files changed

// File: rtl/uart_rx_buffer_pkg.sv
// Shared UART receive constants and the FIFO operation decode used by the receive buffer.
// Each FIFO entry carries the parity-error bit in its MSB above the data word.
package uart_rx_buffer_pkg;

    localparam int UART_WORD_LENGTH = 8;
    localparam int UART_ENTRY_W     = UART_WORD_LENGTH + 1;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_CLEAR,
        OP_PUSH_POP,
        OP_PUSH,
        OP_DROP,
        OP_POP
    } fifo_op_e;

    // Clear beats everything; a simultaneous pop frees the slot a full FIFO needs for a push.
    function automatic fifo_op_e decode_op(input logic clear, input logic wr,
                                           input logic rd, input logic full);
        fifo_op_e op;
        if (clear)
            op = OP_CLEAR;
        else if (wr && rd)
            op = OP_PUSH_POP;
        else if (wr && !full)
            op = OP_PUSH;
        else if (wr)
            op = OP_DROP;
        else if (rd)
            op = OP_POP;
        else
            op = OP_IDLE;
        return op;
    endfunction

endpackage

// File: rtl/uart_rx_buffer_sync_fifo_core.sv
// Show-ahead synchronous FIFO: storage, wrapping pointers and occupancy count.
// The head entry is presented combinationally from the read pointer.
module sync_fifo_core
    import uart_rx_buffer_pkg::*;
#(
    parameter int WIDTH      = UART_ENTRY_W,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full
);

    localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2 + 1)'(1) << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [0:(1 << DEPTH_LOG2) - 1];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign do_pop  = pop & ~empty & ~clear;
    assign do_push = push & (~full | do_pop) & ~clear;
    assign head    = mem[rptr];

    // Storage is deliberately left unreset; Count and Empty gate its visibility.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side elastic buffer: captures one word per Flag_Rx high period into a show-ahead FIFO
// and tracks overrun plus a saturating parity-error count.
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int WORD_LENGTH = UART_WORD_LENGTH,
    parameter int DEPTH_LOG2  = 4,
    parameter bit DROP_BAD    = 1'b0,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Flag_Rx,
    input  logic [WORD_LENGTH-1:0] Parallel_In,
    input  logic                   Parity_Error_In,
    input  logic                   Read,
    input  logic                   Clear,
    output logic [WORD_LENGTH-1:0] Data_Out,
    output logic                   Data_Parity_Error,
    output logic                   Empty,
    output logic                   Full,
    output logic [DEPTH_LOG2:0]    Count,
    output logic                   Overrun,
    output logic [ERR_CNT_W-1:0]   Error_Count
);

    localparam int ENTRY_W = WORD_LENGTH + 1;

    logic               flag_q;
    logic               cap;
    logic               wr;
    logic               rd;
    logic               push;
    logic               pop;
    logic               empty;
    logic               full;
    logic [ENTRY_W-1:0] head;
    fifo_op_e           op;

    assign cap  = Flag_Rx & ~flag_q;
    assign wr   = cap & ~(DROP_BAD & Parity_Error_In);
    assign rd   = Read & ~empty;
    assign op   = decode_op(Clear, wr, rd, full);
    assign push = (op == OP_PUSH) || (op == OP_PUSH_POP);
    assign pop  = (op == OP_POP)  || (op == OP_PUSH_POP);

    sync_fifo_core #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) fifo (
        .clk   (Clk),
        .rst_n (Reset),
        .clear (Clear),
        .push  (push),
        .pop   (pop),
        .wdata ({Parity_Error_In, Parallel_In}),
        .head  (head),
        .count (Count),
        .empty (empty),
        .full  (full)
    );

    assign Empty             = empty;
    assign Full              = full;
    assign Data_Out          = empty ? '0   : head[WORD_LENGTH-1:0];
    assign Data_Parity_Error = empty ? 1'b0 : head[WORD_LENGTH];

    // History resets high so a flag already asserted when reset lifts is not taken as a new word;
    // it keeps tracking through Clear so a long flag is never captured twice.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            flag_q <= 1'b1;
        else
            flag_q <= Flag_Rx;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Overrun     <= 1'b0;
            Error_Count <= '0;
        end else if (Clear) begin
            Overrun     <= 1'b0;
            Error_Count <= '0;
        end else begin
            if (op == OP_DROP)
                Overrun <= 1'b1;
            if (cap && Parity_Error_In && (Error_Count != '1))
                Error_Count <= Error_Count + 1'b1;
        end
    end

endmodule
